cpu_jtag_scan_master: RTL and testbench



---
 rtl/cpu_jtag_scan_pkg.sv | 30 +++
 rtl/cpu_jtag_tck_gen.sv | 39 +++
 rtl/cpu_jtag_scan_master.sv | 140 ++++++++++++++
 tb/tb_cpu_jtag_scan_master.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_jtag_scan_pkg.sv
// Shared definitions for the CPU JTAG scan master: scan state encoding,
// debug-module instruction encodings and default register widths.
// Optional feature macro used by the top: CPU_JTAG_SCAN_IR_CACHE_EN.
package cpu_jtag_scan_pkg;

  localparam int DEF_DR_WIDTH = 38;
  localparam int DEF_IR_WIDTH = 2;

  // Instruction encodings understood by the CPU debug module
  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5,
    ST_RESP = 3'd6
  } scan_state_e;

  // TCK runs only while a virtual JTAG state is being presented
  function automatic logic scan_active(scan_state_e s);
    return (s != ST_IDLE) && (s != ST_RESP);
  endfunction

endpackage

// File: rtl/cpu_jtag_tck_gen.sv
// TCK divider: each period is 2*TCK_DIV clk cycles, low half first.
// tck_rise / tck_fall are one-clk pulses asserted in the cycle before the
// clk edge on which tck goes high / low, so consumers act on that same edge.
module cpu_jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int CW = $clog2(2 * TCK_DIV);

  logic [CW-1:0] cnt;

  assign tck_rise = en && (cnt == CW'(TCK_DIV - 1));
  assign tck_fall = en && (cnt == CW'(2 * TCK_DIV - 1));

  // Phase counter and TCK level; held at period start while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= tck_fall ? '0 : cnt + 1'b1;
      if (tck_rise)
        tck <= 1'b1;
      else if (tck_fall)
        tck <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_jtag_scan_master.sv
// Host-side virtual-JTAG scan engine: one command (IR + DR word) becomes
// UIR, CDR, SDR x DR_WIDTH, UDR, RTI, then a response word captured from TDO.
// Optional feature: CPU_JTAG_SCAN_IR_CACHE_EN skips UIR when the requested
// IR matches the last loaded one.
//
// Handshakes: a transfer happens on a clk edge where valid && ready are both
// high; valid is held by the producer until that edge, and rsp_valid stays
// high with rsp_data stable until rsp_ready is seen.
module cpu_jtag_scan_master
  import cpu_jtag_scan_pkg::*;
#(
  parameter int DR_WIDTH = DEF_DR_WIDTH,
  parameter int IR_WIDTH = DEF_IR_WIDTH,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [2:0]          dbg_state
);

  localparam int BW = $clog2(DR_WIDTH + 1);

  scan_state_e         state, next_state;
  logic                cmd_fire;
  logic                ir_hit;
  logic                tck_rise, tck_fall;
  logic [DR_WIDTH-1:0] shreg;
  logic [BW-1:0]       bit_cnt;

  cpu_jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (scan_active(state)),
    .tck      (vji_tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  assign cmd_ready = !reset && (state == ST_IDLE) && !rsp_valid;
  assign vji_uir   = (state == ST_UIR);
  assign vji_cdr   = (state == ST_CDR);
  assign vji_sdr   = (state == ST_SDR);
  assign vji_udr   = (state == ST_UDR);
  assign vji_rti   = (state == ST_RTI);
  assign dbg_state = state;

`ifdef CPU_JTAG_SCAN_IR_CACHE_EN
  logic ir_cache_valid;

  // vji_ir_in doubles as the cached IR; this flag says whether it is trusted
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ir_cache_valid <= 1'b0;
    else if (cmd_fire)
      ir_cache_valid <= 1'b1;
  end

  assign ir_hit = ir_cache_valid && (cmd_ir == vji_ir_in);
`else
  assign ir_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // Next-state logic: all scan states advance only on TCK falling edges
  always_comb begin
    next_state = state;
    cmd_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_fire   = 1'b1;
          next_state = ir_hit ? ST_CDR : ST_UIR;
        end
      end
      ST_UIR:  if (tck_fall) next_state = ST_CDR;
      ST_CDR:  if (tck_fall) next_state = ST_SDR;
      ST_SDR:  if (tck_fall && (bit_cnt == BW'(DR_WIDTH - 1))) next_state = ST_UDR;
      ST_UDR:  if (tck_fall) next_state = ST_RTI;
      ST_RTI:  if (tck_fall) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Shift register, TDI, IR and response datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (cmd_fire) begin
        shreg <= cmd_data;
        if (!ir_hit)
          vji_ir_in <= cmd_ir;
      end
      // TDO enters at the top, so the first captured bit ends at bit 0
      if ((state == ST_SDR) && tck_rise)
        shreg <= {vji_tdo, shreg[DR_WIDTH-1:1]};
      // bit_cnt counts SDR periods already completed
      if (tck_fall) begin
        vji_tdi <= (next_state == ST_SDR) ? shreg[0] : 1'b0;
        bit_cnt <= (state == ST_SDR) ? bit_cnt + 1'b1 : '0;
      end
      if (state == ST_RESP) begin
        rsp_valid <= 1'b1;
        rsp_data  <= shreg;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_jtag_scan_master.sv
// Bench for cpu_jtag_scan_master: behavioural timeline model of the scan
// sequence, per-cycle compare process, response scoreboard and directed
// plus randomized command stimulus.
module tb_cpu_jtag_scan_master;
  import cpu_jtag_scan_pkg::*;

  localparam int DR  = 38;
  localparam int IRW = 2;
  localparam int DIV = 2;
  localparam int PER = 2 * DIV;
  localparam int FULL_LAT = (DR + 4) * PER + 1;
`ifdef CPU_JTAG_SCAN_IR_CACHE_EN
  localparam int HIT_LAT = 165;
  localparam int HIT_UIR = 0;
`else
  localparam int HIT_LAT = 169;
  localparam int HIT_UIR = PER;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [IRW-1:0] cmd_ir = '0;
  logic [DR-1:0]  cmd_data = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [DR-1:0]  rsp_data;
  logic           vji_tck, vji_tdi, vji_tdo;
  logic [IRW-1:0] vji_ir_in;
  logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [2:0]     dbg_state;

  always #5 clk = ~clk;

  cpu_jtag_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IRW), .TCK_DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
    .vji_rti(vji_rti), .dbg_state(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- TDO source ----------------
  // Mode 0 loops TDI back; mode 1 plays tdo_pattern, bit i during SDR period i.
  logic          tdo_mode = 1'b0;
  logic [DR-1:0] tdo_pattern = '0;
  int            sdr_idx = 0;
  int            uir_total = 0;
  logic          tck_seen = 1'b0;

  always_comb vji_tdo = tdo_mode ? ((sdr_idx < DR) ? tdo_pattern[sdr_idx] : 1'b0) : vji_tdi;

  // Counts TCK rises inside SDR and clk cycles spent in UIR
  always @(negedge clk) begin
    if (reset) begin
      sdr_idx  = 0;
      tck_seen = 1'b0;
    end else begin
      if (vji_cdr || vji_uir) sdr_idx = 0;
      else if (vji_sdr && vji_tck && !tck_seen) sdr_idx++;
      if (vji_uir) uir_total++;
      tck_seen = vji_tck;
    end
  end

  // ---------------- behavioural model + scoreboard ----------------
  logic          m_active = 1'b0;
  logic          m_pend = 1'b0;
  logic          m_cached = 1'b0;
  logic          m_cache_v = 1'b0;
  int            m_n = 0;
  int            m_len = 0;
  logic [DR-1:0] m_data = '0;
  logic [IRW-1:0] m_ir = '0;
  logic [DR-1:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active  = 1'b0;
      m_pend    = 1'b0;
      m_cache_v = 1'b0;
      m_ir      = '0;
      exp_q.delete();
    end else begin
      logic hs, acc;
      hs  = cmd_valid && !m_active && !m_pend;
      acc = m_pend && rsp_ready;
      if (m_active) begin
        m_n++;
        if (m_n == m_len + 1) begin
          m_active = 1'b0;
          m_pend   = 1'b1;
        end
      end
      if (acc) begin
        m_pend = 1'b0;
        void'(exp_q.pop_front());
      end
      if (hs) begin
`ifdef CPU_JTAG_SCAN_IR_CACHE_EN
        m_cached = m_cache_v && (cmd_ir == m_ir);
`else
        m_cached = 1'b0;
`endif
        m_len     = (m_cached ? DR + 3 : DR + 4) * PER;
        m_ir      = cmd_ir;
        m_cache_v = 1'b1;
        m_data    = cmd_data;
        m_active  = 1'b1;
        m_n       = 0;
        exp_q.push_back(tdo_mode ? tdo_pattern : cmd_data);
      end
    end
  end

  // Per-cycle compare: phase index 0=UIR,1=CDR,2..DR+1=SDR,DR+2=UDR,DR+3=RTI
  always @(negedge clk) begin
    int   ph;
    logic e_tck;
    ph    = -1;
    e_tck = 1'b0;
    if (reset) begin
      check("rst_tck", vji_tck, 0);
      check("rst_tdi", vji_tdi, 0);
      check("rst_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
      check("rst_ir_in", vji_ir_in, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
    end else begin
      if (m_active && m_n < m_len) begin
        ph    = (m_n / PER) + (m_cached ? 1 : 0);
        e_tck = (m_n % PER) >= DIV;
      end
      check("cmd_ready", cmd_ready, !m_active && !m_pend);
      check("tck", vji_tck, e_tck);
      check("uir", vji_uir, ph == 0);
      check("cdr", vji_cdr, ph == 1);
      check("sdr", vji_sdr, ph >= 2 && ph <= DR + 1);
      check("udr", vji_udr, ph == DR + 2);
      check("rti", vji_rti, ph == DR + 3);
      check("ir_in", vji_ir_in, m_ir);
      check("rsp_valid", rsp_valid, m_pend);
      if (ph >= 2 && ph <= DR + 1) check("tdi", vji_tdi, m_data[ph-2]);
      if (m_pend && exp_q.size() > 0) check("rsp_data", rsp_data, exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  int hs_cyc = 0;

  // Called shortly after a rising clk edge
  task automatic send_cmd(input logic [IRW-1:0] ir, input logic [DR-1:0] data);
    logic got;
    got = 1'b0;
    cmd_ir    = ir;
    cmd_data  = data;
    cmd_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    hs_cyc = cyc;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL send_cmd_timeout: cmd_ready never high, required 1");
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc - hs_cyc;
        break;
      end
    end
    if (lat < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_rsp_timeout: rsp_valid never high, required 1");
    end
  endtask

  task automatic pulse_rsp_ready();
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, u0;
    logic [DR-1:0] d;

    // Reset for 3 clk, then static idle outputs
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_rsp_data", rsp_data, 0);
    repeat (8) begin
      @(negedge clk);
      check("idle_tck_static", vji_tck, 0);
    end

    // Loopback with a known word
    @(posedge clk); #1;
    tdo_mode = 1'b0;
    send_cmd(IR_BREAK, 38'h2_AAAA_5555);
    wait_rsp(lat);
    check("loop_latency", lat, 169);
    check("loop_rsp_data", rsp_data, 38'h2_AAAA_5555);
    check("loop_ir_in", vji_ir_in, 2'b10);

    // TDO tied high: all-ones response, exactly DR rises in SDR
    @(posedge clk); #1;
    tdo_mode    = 1'b1;
    tdo_pattern = '1;
    send_cmd(IR_OCIMEM, DR'({$urandom(), $urandom()}));
    wait_rsp(lat);
    check("ones_rsp_data", rsp_data, 38'h3F_FFFF_FFFF);
    check("ones_sdr_rises", sdr_idx, 38);

    // IR cache: same IR twice
    @(posedge clk); #1;
    tdo_mode = 1'b0;
    u0 = uir_total;
    send_cmd(IR_TRACEMEM, DR'({$urandom(), $urandom()}));
    wait_rsp(lat);
    check("cache1_latency", lat, FULL_LAT);
    check("cache1_uir_cycles", uir_total - u0, PER);
    @(posedge clk); #1;
    u0 = uir_total;
    send_cmd(IR_TRACEMEM, DR'({$urandom(), $urandom()}));
    wait_rsp(lat);
    check("cache2_latency", lat, HIT_LAT);
    check("cache2_uir_cycles", uir_total - u0, HIT_UIR);

    // Reset in the middle of SDR
    @(posedge clk); #1;
    send_cmd(IR_TRACEMEM, DR'({$urandom(), $urandom()}));
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (vji_sdr && sdr_idx == 9) break;
    end
    reset = 1'b1;
    #1;
    check("midrst_tck", vji_tck, 0);
    check("midrst_tdi", vji_tdi, 0);
    check("midrst_sdr", vji_sdr, 0);
    check("midrst_ir_in", vji_ir_in, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    u0 = uir_total;
    send_cmd(IR_TRACEMEM, DR'({$urandom(), $urandom()}));
    wait_rsp(lat);
    check("postrst_latency", lat, 169);
    check("postrst_uir_cycles", uir_total - u0, PER);

    // Backpressure: response held, new command waits
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    d = DR'({$urandom(), $urandom()});
    send_cmd(IR_OCIMEM, d);
    wait_rsp(lat);
    check("bp_first_latency", lat, 169);
    @(posedge clk); #1;
    cmd_ir    = IR_BREAK;
    cmd_data  = DR'({$urandom(), $urandom()});
    cmd_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_rsp_stable", rsp_data, d);
    end
    pulse_rsp_ready();
    @(negedge clk);
    check("bp_ready_after_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    hs_cyc = cyc;
    wait_rsp(lat);
    check("bp_second_latency", lat, 169);
    pulse_rsp_ready();

    // Randomized commands, TDO sources and response delays
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      tdo_mode    = 1'($urandom_range(0, 1));
      tdo_pattern = DR'({$urandom(), $urandom()});
      send_cmd(IRW'($urandom_range(0, 3)), DR'({$urandom(), $urandom()}));
      wait_rsp(lat);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      pulse_rsp_ready();
    end

    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
